// File: rtl/dac_spi_driver_if.sv
// Sample handshake plus DAC serial pins between the DDS datapath and dac_spi_driver.
// The slave modport is the driver's view; the master modport is the upstream/board side.
interface dac_spi_driver_if;
    logic        SampleValid;
    logic [11:0] Sample;
    logic        Ready;
    logic        Dac_CSn;
    logic        Dac_SCK;
    logic        Dac_SDI;
    logic        Dac_LDACn;
    logic        FrameDone;
    logic [7:0]  DropCnt;

    modport slave (
        input  SampleValid, Sample,
        output Ready, Dac_CSn, Dac_SCK, Dac_SDI, Dac_LDACn, FrameDone, DropCnt
    );

    modport master (
        output SampleValid, Sample,
        input  Ready, Dac_CSn, Dac_SCK, Dac_SDI, Dac_LDACn, FrameDone, DropCnt
    );
endinterface

// File: rtl/dac_spi_driver.sv
// Ships each accepted 12-bit sample as a 16-bit MCP4921-style SPI frame, then pulses LDAC.
// All DAC pins are registered; SCK is produced by a divider, never by gating the clock.
module dac_spi_driver #(
    parameter int         CLK_DIV     = 2,
    parameter logic [3:0] CONFIG_BITS = 4'b0011
) (
    input  logic            Fg_CLK,
    input  logic            RESETn,
    dac_spi_driver_if.slave dac
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    state_t        state_r,   state_nxt_s;
    logic [CW-1:0] div_cnt_r, div_cnt_nxt_s;
    logic [3:0]    bit_cnt_r, bit_cnt_nxt_s;
    logic [14:0]   shift_r,   shift_nxt_s;
    logic          sck_r,     sck_nxt_s;
    logic          sdi_r,     sdi_nxt_s;
    logic          csn_r,     csn_nxt_s;
    logic          ldacn_r,   ldacn_nxt_s;
    logic          ready_r,   ready_nxt_s;
    logic          done_r,    done_nxt_s;
    logic [7:0]    drop_r,    drop_nxt_s;
    logic          div_last_s;

    // Next-state and next-output logic for the frame sequencer and drop counter
    always_comb begin
        state_nxt_s   = state_r;
        div_cnt_nxt_s = div_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        sck_nxt_s     = sck_r;
        sdi_nxt_s     = sdi_r;
        csn_nxt_s     = csn_r;
        ldacn_nxt_s   = ldacn_r;
        ready_nxt_s   = ready_r;
        done_nxt_s    = 1'b0;
        div_last_s    = (div_cnt_r == DIV_LAST);

        case (state_r)
            ST_IDLE: begin
                div_cnt_nxt_s = '0;
                if (dac.SampleValid) begin
                    state_nxt_s   = ST_SETUP;
                    ready_nxt_s   = 1'b0;
                    csn_nxt_s     = 1'b0;
                    bit_cnt_nxt_s = 4'd0;
                    shift_nxt_s   = {CONFIG_BITS[2:0], dac.Sample};
                    sdi_nxt_s     = CONFIG_BITS[3];
                end else begin
                    ready_nxt_s   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_last_s) begin
                    div_cnt_nxt_s = '0;
                    state_nxt_s   = ST_SHIFT;
                    sck_nxt_s     = 1'b1;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (!div_last_s) begin
                    div_cnt_nxt_s = div_cnt_r + CW'(1);
                end else if (sck_r) begin
                    // Falling SCK is the only point where SDI advances to the next bit
                    div_cnt_nxt_s = '0;
                    sck_nxt_s     = 1'b0;
                    sdi_nxt_s     = shift_r[14];
                    shift_nxt_s   = {shift_r[13:0], 1'b0};
                end else if (bit_cnt_r == 4'd15) begin
                    div_cnt_nxt_s = '0;
                    state_nxt_s   = ST_HOLD;
                end else begin
                    div_cnt_nxt_s = '0;
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    sck_nxt_s     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_last_s) begin
                    div_cnt_nxt_s = '0;
                    state_nxt_s   = ST_LATCH;
                    csn_nxt_s     = 1'b1;
                    ldacn_nxt_s   = 1'b0;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + CW'(1);
                end
            end
            ST_LATCH: begin
                if (div_last_s) begin
                    div_cnt_nxt_s = '0;
                    state_nxt_s   = ST_IDLE;
                    ldacn_nxt_s   = 1'b1;
                    done_nxt_s    = 1'b1;
                    ready_nxt_s   = 1'b1;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                div_cnt_nxt_s = '0;
                sck_nxt_s     = 1'b0;
                csn_nxt_s     = 1'b1;
                ldacn_nxt_s   = 1'b1;
                ready_nxt_s   = 1'b1;
            end
        endcase

        if (dac.SampleValid && !ready_r && (drop_r != 8'hFF)) begin
            drop_nxt_s = drop_r + 8'd1;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // State and output registers; synchronous reset aborts any frame without LDAC
    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= '0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 15'd0;
            sck_r     <= 1'b0;
            sdi_r     <= 1'b0;
            csn_r     <= 1'b1;
            ldacn_r   <= 1'b1;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            drop_r    <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            div_cnt_r <= div_cnt_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            sck_r     <= sck_nxt_s;
            sdi_r     <= sdi_nxt_s;
            csn_r     <= csn_nxt_s;
            ldacn_r   <= ldacn_nxt_s;
            ready_r   <= ready_nxt_s;
            done_r    <= done_nxt_s;
            drop_r    <= drop_nxt_s;
        end
    end

    assign dac.Ready     = ready_r;
    assign dac.Dac_CSn   = csn_r;
    assign dac.Dac_SCK   = sck_r;
    assign dac.Dac_SDI   = sdi_r;
    assign dac.Dac_LDACn = ldacn_r;
    assign dac.FrameDone = done_r;
    assign dac.DropCnt   = drop_r;
endmodule
